// File: rtl/flash_array_seq.sv
`default_nettype none
// ============================================================================
// Module      : flash_array_seq
// Description : Control sequencer for the 8x8 flash array macro. It takes
//               READ / PROGRAM / ERASE commands over a valid/ready channel,
//               produces the timed select-line, word-line, well-bias and
//               sense-amp waveforms, captures the 8-bit sense output and
//               returns one response per command over a second channel.
//
//   Ports
//     wb_clk_i, wb_rst_n           clock, asynchronous active-low reset
//     cmd_valid/cmd_ready          command handshake (ready only in IDLE)
//     cmd_op                       00 READ, 01 PROGRAM, 10 ERASE, 11 reserved
//     cmd_addr                     [2] string select, [1:0] word line
//     cmd_wdata                    program data, 1 = program that bit
//     rsp_valid/rsp_ready          response handshake
//     rsp_rdata, rsp_err           read data, error flag
//     busy                         sequencer not idle
//     SSL, GSL, WL0, WL1           string/ground selects and word lines
//     SL, VBPW                     source line, p-well bias (erase)
//     sen1, sen2, out_en           sense-amp precharge/evaluate/output enable
//     arr_out                      array sense output
//     bl_drv, bl_oe                bit-line drive data and enable
//
//   Build option
//     FLASH_SEQ_VERIFY_EN : when defined, every PROGRAM is followed by a
//                           read-back of the same address; rsp_err flags
//                           any bit that was meant to program but still
//                           reads 1, and rsp_rdata carries the read-back.
//
// Revision    : 1.0 - initial release
// ============================================================================
module flash_array_seq #(
    parameter int CNT_W     = 16,
    parameter int SETUP_CYC = 4,
    parameter int PRECH_CYC = 8,
    parameter int SENSE_CYC = 8,
    parameter int PGM_CYC   = 64,
    parameter int ERASE_CYC = 256
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       busy,
    output logic [1:0] SSL,
    output logic [1:0] GSL,
    output logic [3:0] WL0,
    output logic [3:0] WL1,
    output logic       SL,
    output logic       VBPW,
    output logic       sen1,
    output logic       sen2,
    output logic [3:0] out_en,
    input  logic [7:0] arr_out,
    output logic [7:0] bl_drv,
    output logic       bl_oe
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_setup   = 3'd1;
    localparam logic [2:0] c_st_prech   = 3'd2;
    localparam logic [2:0] c_st_sense   = 3'd3;
    localparam logic [2:0] c_st_latch   = 3'd4;
    localparam logic [2:0] c_st_pulse   = 3'd5;
    localparam logic [2:0] c_st_recover = 3'd6;
    localparam logic [2:0] c_st_resp    = 3'd7;

    localparam logic [1:0] c_op_read  = 2'b00;
    localparam logic [1:0] c_op_pgm   = 2'b01;
    localparam logic [1:0] c_op_erase = 2'b10;
    localparam logic [1:0] c_op_rsvd  = 2'b11;

    // Timer reload values: a phase of N cycles loads N-1; N of 0 behaves as 1.
    localparam logic [CNT_W-1:0] c_ld_setup = (SETUP_CYC <= 1) ? '0 : CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] c_ld_prech = (PRECH_CYC <= 1) ? '0 : CNT_W'(PRECH_CYC - 1);
    localparam logic [CNT_W-1:0] c_ld_sense = (SENSE_CYC <= 1) ? '0 : CNT_W'(SENSE_CYC - 1);
    localparam logic [CNT_W-1:0] c_ld_pgm   = (PGM_CYC   <= 1) ? '0 : CNT_W'(PGM_CYC - 1);
    localparam logic [CNT_W-1:0] c_ld_erase = (ERASE_CYC <= 1) ? '0 : CNT_W'(ERASE_CYC - 1);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_timer;
    logic [1:0]       r_op;
    logic [2:0]       r_addr;
    logic [7:0]       r_wdata;
    logic [7:0]       r_rdata;
    logic             r_err;
`ifdef FLASH_SEQ_VERIFY_EN
    logic             r_verify;
`endif

    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_timer_nxt;
    logic             w_accept;
    logic             w_verify_start;
    logic [1:0]       w_op;
    logic [2:0]       w_addr;
    logic [7:0]       w_wdata;
    logic             w_timer_zero;

    assign w_timer_zero = (r_timer == '0);

    // ------------------------------------------------------------------
    // Next-state and timer
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer;
        w_accept       = 1'b0;
        w_verify_start = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    if (cmd_op == c_op_rsvd) begin
                        w_state_nxt = c_st_resp;
                        w_timer_nxt = '0;
                    end else begin
                        w_state_nxt = c_st_setup;
                        w_timer_nxt = c_ld_setup;
                    end
                end
            end
            c_st_setup: begin
                if (w_timer_zero) begin
                    if (r_op == c_op_read) begin
                        w_state_nxt = c_st_prech;
                        w_timer_nxt = c_ld_prech;
                    end else begin
                        w_state_nxt = c_st_pulse;
                        w_timer_nxt = (r_op == c_op_erase) ? c_ld_erase : c_ld_pgm;
                    end
                end else begin
                    w_timer_nxt = r_timer - c_one;
                end
            end
            c_st_prech: begin
                if (w_timer_zero) begin
                    w_state_nxt = c_st_sense;
                    w_timer_nxt = c_ld_sense;
                end else begin
                    w_timer_nxt = r_timer - c_one;
                end
            end
            c_st_sense: begin
                if (w_timer_zero) begin
                    w_state_nxt = c_st_latch;
                end else begin
                    w_timer_nxt = r_timer - c_one;
                end
            end
            c_st_latch: begin
                w_state_nxt = c_st_recover;
                w_timer_nxt = '0;
            end
            c_st_pulse: begin
                if (w_timer_zero) begin
                    w_state_nxt = c_st_recover;
                end else begin
                    w_timer_nxt = r_timer - c_one;
                end
            end
            c_st_recover: begin
                w_state_nxt = c_st_resp;
                w_timer_nxt = '0;
`ifdef FLASH_SEQ_VERIFY_EN
                // A finished program pulse loops back through a full read
                // of the same cell; r_op becomes READ so this fires once.
                if (r_op == c_op_pgm) begin
                    w_state_nxt    = c_st_setup;
                    w_timer_nxt    = c_ld_setup;
                    w_verify_start = 1'b1;
                end
`endif
            end
            c_st_resp: begin
                if (rsp_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_timer_nxt = '0;
            end
        endcase
    end

    // Command fields as they will be seen in the next state; on the accept
    // edge they come straight from the command port.
    assign w_op    = w_accept ? cmd_op : (w_verify_start ? c_op_read : r_op);
    assign w_addr  = w_accept ? cmd_addr  : r_addr;
    assign w_wdata = w_accept ? cmd_wdata : r_wdata;

    // ------------------------------------------------------------------
    // Array control decode for the next state (registered below)
    // ------------------------------------------------------------------
    logic [1:0] w_ssl;
    logic [1:0] w_gsl;
    logic [3:0] w_wl0;
    logic [3:0] w_wl1;
    logic [3:0] w_wl_pat;
    logic       w_wl_en;
    logic       w_sl_vbpw;
    logic       w_bl_oe;
    logic [7:0] w_bl_drv;
    logic       w_read_ph;
    logic       w_pgm_ph;

    always_comb begin
        w_ssl     = 2'b00;
        w_gsl     = 2'b00;
        w_wl0     = 4'h0;
        w_wl1     = 4'h0;
        w_wl_pat  = 4'h0;
        w_wl_en   = 1'b0;
        w_sl_vbpw = 1'b0;
        w_bl_oe   = 1'b0;
        w_bl_drv  = 8'h00;
        w_read_ph = (w_op == c_op_read) &&
                    ((w_state_nxt == c_st_setup) || (w_state_nxt == c_st_prech) ||
                     (w_state_nxt == c_st_sense) || (w_state_nxt == c_st_latch));
        w_pgm_ph  = (w_op == c_op_pgm) &&
                    ((w_state_nxt == c_st_setup) || (w_state_nxt == c_st_pulse));
        if (w_read_ph) begin
            // Unselected cells pass; the addressed WL at 0 is the one sensed.
            w_ssl[w_addr[2]] = 1'b1;
            w_gsl[w_addr[2]] = 1'b1;
            w_wl_pat         = ~(4'b0001 << w_addr[1:0]);
            w_wl_en          = 1'b1;
        end else if (w_pgm_ph) begin
            w_ssl[w_addr[2]] = 1'b1;
            w_wl_pat         = 4'hF;
            w_wl_en          = 1'b1;
            w_bl_oe          = 1'b1;
            // Bit lines driven low select the cells to be programmed.
            w_bl_drv         = ~w_wdata;
        end else if ((w_op == c_op_erase) && (w_state_nxt == c_st_pulse)) begin
            w_sl_vbpw = 1'b1;
        end
        if (w_wl_en) begin
            if (w_addr[2]) begin
                w_wl1 = w_wl_pat;
            end else begin
                w_wl0 = w_wl_pat;
            end
        end
    end

    // ------------------------------------------------------------------
    // State, command latch and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state   <= c_st_idle;
            r_timer   <= '0;
            r_op      <= c_op_read;
            r_addr    <= 3'b000;
            r_wdata   <= 8'h00;
            r_rdata   <= 8'h00;
            r_err     <= 1'b0;
`ifdef FLASH_SEQ_VERIFY_EN
            r_verify  <= 1'b0;
`endif
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            SSL       <= 2'b00;
            GSL       <= 2'b00;
            WL0       <= 4'h0;
            WL1       <= 4'h0;
            SL        <= 1'b0;
            VBPW      <= 1'b0;
            sen1      <= 1'b0;
            sen2      <= 1'b0;
            out_en    <= 4'h0;
            bl_drv    <= 8'h00;
            bl_oe     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            if (w_accept) begin
                r_op    <= cmd_op;
                r_addr  <= cmd_addr;
                r_wdata <= cmd_wdata;
                r_rdata <= 8'h00;
                r_err   <= (cmd_op == c_op_rsvd);
`ifdef FLASH_SEQ_VERIFY_EN
                r_verify <= 1'b0;
`endif
            end
`ifdef FLASH_SEQ_VERIFY_EN
            if (w_verify_start) begin
                r_op     <= c_op_read;
                r_verify <= 1'b1;
            end
`endif
            if (r_state == c_st_latch) begin
                r_rdata <= arr_out;
`ifdef FLASH_SEQ_VERIFY_EN
                // A programmed cell reads 0; a 1 where data asked for
                // programming means the cell did not take.
                if (r_verify) begin
                    r_err <= |(arr_out & r_wdata);
                end
`endif
            end
            cmd_ready <= (w_state_nxt == c_st_idle);
            rsp_valid <= (w_state_nxt == c_st_resp);
            busy      <= (w_state_nxt != c_st_idle);
            SSL       <= w_ssl;
            GSL       <= w_gsl;
            WL0       <= w_wl0;
            WL1       <= w_wl1;
            SL        <= w_sl_vbpw;
            VBPW      <= w_sl_vbpw;
            sen1      <= (w_state_nxt == c_st_prech);
            sen2      <= (w_state_nxt == c_st_sense) || (w_state_nxt == c_st_latch);
            out_en    <= (w_state_nxt == c_st_latch) ? 4'hF : 4'h0;
            bl_drv    <= w_bl_drv;
            bl_oe     <= w_bl_oe;
        end
    end

    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_flash_array_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_flash_array_seq
// Description : Directed self-checking bench for flash_array_seq: reset,
//               READ, ERASE, PROGRAM (with or without FLASH_SEQ_VERIFY_EN),
//               reserved op, response back-pressure and reset mid-sense.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_array_seq;

    logic       wb_clk_i  = 1'b0;
    logic       wb_rst_n  = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op    = 2'b00;
    logic [2:0] cmd_addr  = 3'b000;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_ready = 1'b0;
    logic [7:0] arr_out   = 8'h00;
    logic       cmd_ready, rsp_valid, rsp_err, busy;
    logic [7:0] rsp_rdata, bl_drv;
    logic [1:0] SSL, GSL;
    logic [3:0] WL0, WL1, out_en;
    logic       SL, VBPW, sen1, sen2, bl_oe;

    flash_array_seq dut (
        .wb_clk_i (wb_clk_i),  .wb_rst_n (wb_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr (cmd_addr),  .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),   .busy(busy),
        .SSL(SSL), .GSL(GSL), .WL0(WL0), .WL1(WL1), .SL(SL), .VBPW(VBPW),
        .sen1(sen1), .sen2(sen2), .out_en(out_en), .arr_out(arr_out),
        .bl_drv(bl_drv), .bl_oe(bl_oe)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int total = 0;
    int bad   = 0;

    // Observations gathered while a command runs
    int         rsp_cyc, n_sen1, n_sen2_only, n_outen, n_slvb, n_bloe;
    int         first_sen1, first_sen2, n_overlap;
    logic [1:0] or_ssl, or_gsl, s_ssl, s_gsl;
    logic [3:0] or_wl0, or_wl1, s_wl0, s_wl1;
    logic [7:0] s_bldrv;
    logic       or_ctl;
    logic [40:0] all_out;

    assign all_out = {cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, SSL, GSL,
                      WL0, WL1, SL, VBPW, sen1, sen2, out_en, bl_drv, bl_oe};

    // Issue one command and watch the array pins until rsp_valid or limit.
    // Cycle 1 is the cycle right after the accept edge.
    task automatic run_cmd(input logic [1:0] op, input logic [2:0] addr,
                           input logic [7:0] wd, input int limit);
        @(negedge wb_clk_i);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd;
        rsp_cyc = 0; n_sen1 = 0; n_sen2_only = 0; n_outen = 0; n_slvb = 0;
        n_bloe = 0; first_sen1 = 0; first_sen2 = 0; n_overlap = 0;
        or_ssl = 0; or_gsl = 0; or_wl0 = 0; or_wl1 = 0; or_ctl = 0;
        for (int k = 1; k <= limit; k++) begin
            @(posedge wb_clk_i); #1;
            if (k == 1) begin
                cmd_valid = 1'b0;
                s_ssl = SSL; s_gsl = GSL; s_wl0 = WL0; s_wl1 = WL1; s_bldrv = bl_drv;
            end
            if (sen1) begin n_sen1++; if (first_sen1 == 0) first_sen1 = k; end
            if (sen2 && first_sen2 == 0) first_sen2 = k;
            if (sen2 && out_en == 4'h0) n_sen2_only++;
            if (out_en == 4'hF) n_outen++;
            if (SL && VBPW) n_slvb++;
            if (bl_oe) n_bloe++;
            if ((sen1 && sen2) || (bl_oe && (sen1 || sen2))) n_overlap++;
            or_ssl |= SSL; or_gsl |= GSL; or_wl0 |= WL0; or_wl1 |= WL1;
            or_ctl |= (|{SSL, GSL, WL0, WL1, SL, VBPW, sen1, sen2, out_en, bl_oe, bl_drv});
            if (rsp_valid) begin rsp_cyc = k; break; end
        end
    endtask

    task automatic ack_rsp();
        @(negedge wb_clk_i); rsp_ready = 1'b1;
        @(posedge wb_clk_i); #1; rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        wb_rst_n = 1'b0;
        repeat (2) @(posedge wb_clk_i); #1;
        total++; if (all_out !== 41'd0) begin bad++; $display("FAIL reset_outputs got=%h want=0", all_out); end
        @(negedge wb_clk_i); wb_rst_n = 1'b1;
        @(posedge wb_clk_i); #1;
        total++; if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin bad++; $display("FAIL reset_idle got=%b want=100", {cmd_ready, busy, rsp_valid}); end
    endtask

    task automatic test_read();
        arr_out = 8'hA5;
        run_cmd(2'b00, 3'b101, 8'h00, 40);
        total++; if ({s_ssl, s_gsl} !== 4'b1010) begin bad++; $display("FAIL read_sel got=%b want=1010", {s_ssl, s_gsl}); end
        total++; if ({s_wl1, s_wl0} !== 8'b1101_0000) begin bad++; $display("FAIL read_wl got=%b want=11010000", {s_wl1, s_wl0}); end
        total++; if ({or_ssl, or_gsl, or_wl0} !== 8'b1010_0000) begin bad++; $display("FAIL read_unaddr_toggle got=%b want=10100000", {or_ssl, or_gsl, or_wl0}); end
        total++; if (first_sen1 !== 5 || n_sen1 !== 8) begin bad++; $display("FAIL read_sen1 got=%0d/%0d want=5/8", first_sen1, n_sen1); end
        total++; if (first_sen2 !== 13 || n_sen2_only !== 8) begin bad++; $display("FAIL read_sen2 got=%0d/%0d want=13/8", first_sen2, n_sen2_only); end
        total++; if (n_outen !== 1) begin bad++; $display("FAIL read_out_en got=%0d want=1", n_outen); end
        total++; if (n_overlap !== 0) begin bad++; $display("FAIL read_overlap got=%0d want=0", n_overlap); end
        total++; if (rsp_cyc !== 23) begin bad++; $display("FAIL read_latency got=%0d want=23", rsp_cyc); end
        total++; if ({rsp_rdata, rsp_err} !== {8'hA5, 1'b0}) begin bad++; $display("FAIL read_rsp got=%h/%b want=a5/0", rsp_rdata, rsp_err); end
        ack_rsp();
        total++; if ({rsp_valid, cmd_ready} !== 2'b01) begin bad++; $display("FAIL read_ack got=%b want=01", {rsp_valid, cmd_ready}); end
    endtask

    task automatic test_erase();
        arr_out = 8'hFF;
        run_cmd(2'b10, 3'b000, 8'h00, 300);
        total++; if (n_slvb !== 256) begin bad++; $display("FAIL erase_pulse got=%0d want=256", n_slvb); end
        total++; if ({or_wl0, or_wl1, or_ssl, or_gsl} !== 12'd0) begin bad++; $display("FAIL erase_lines got=%h want=0", {or_wl0, or_wl1, or_ssl, or_gsl}); end
        total++; if (rsp_cyc !== 262) begin bad++; $display("FAIL erase_latency got=%0d want=262", rsp_cyc); end
        total++; if ({rsp_rdata, rsp_err} !== 9'd0) begin bad++; $display("FAIL erase_rsp got=%h/%b want=00/0", rsp_rdata, rsp_err); end
        ack_rsp();
    endtask

    task automatic test_program();
        int         exp_lat;
        logic [8:0] exp_rsp;
`ifdef FLASH_SEQ_VERIFY_EN
        exp_lat = 92; exp_rsp = {8'h01, 1'b1};
`else
        exp_lat = 70; exp_rsp = {8'h00, 1'b0};
`endif
        arr_out = 8'h01;
        run_cmd(2'b01, 3'b010, 8'h0F, 150);
        total++; if (n_bloe !== 68) begin bad++; $display("FAIL pgm_bl_oe got=%0d want=68", n_bloe); end
        total++; if (s_bldrv !== 8'hF0) begin bad++; $display("FAIL pgm_bl_drv got=%h want=f0", s_bldrv); end
        total++; if ({s_wl0, s_wl1, s_ssl, s_gsl} !== 12'b1111_0000_01_00) begin bad++; $display("FAIL pgm_lines got=%b want=111100000100", {s_wl0, s_wl1, s_ssl, s_gsl}); end
        total++; if ({or_wl1, or_ssl[1], or_gsl[1]} !== 6'd0) begin bad++; $display("FAIL pgm_unaddr_toggle got=%b want=0", {or_wl1, or_ssl[1], or_gsl[1]}); end
        total++; if (n_overlap !== 0) begin bad++; $display("FAIL pgm_overlap got=%0d want=0", n_overlap); end
        total++; if (rsp_cyc !== exp_lat) begin bad++; $display("FAIL pgm_latency got=%0d want=%0d", rsp_cyc, exp_lat); end
        total++; if ({rsp_rdata, rsp_err} !== exp_rsp) begin bad++; $display("FAIL pgm_rsp got=%h want=%h", {rsp_rdata, rsp_err}, exp_rsp); end
        ack_rsp();
    endtask

    task automatic test_reserved();
        run_cmd(2'b11, 3'b111, 8'hFF, 10);
        total++; if (rsp_cyc !== 1) begin bad++; $display("FAIL rsvd_latency got=%0d want=1", rsp_cyc); end
        total++; if ({rsp_rdata, rsp_err} !== {8'h00, 1'b1}) begin bad++; $display("FAIL rsvd_rsp got=%h/%b want=00/1", rsp_rdata, rsp_err); end
        total++; if (or_ctl !== 1'b0) begin bad++; $display("FAIL rsvd_no_toggle got=%b want=0", or_ctl); end
        ack_rsp();
    endtask

    task automatic test_back_to_back();
        int found;
        arr_out = 8'h3C;
        run_cmd(2'b00, 3'b011, 8'h00, 40);
        total++; if (rsp_cyc !== 23) begin bad++; $display("FAIL bp_latency got=%0d want=23", rsp_cyc); end
        @(negedge wb_clk_i); cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 3'b001;
        for (int i = 0; i < 10; i++) begin
            @(posedge wb_clk_i); #1;
            total++; if ({cmd_ready, rsp_valid, rsp_rdata} !== {2'b01, 8'h3C}) begin bad++; $display("FAIL bp_hold[%0d] got=%b/%h want=01/3c", i, {cmd_ready, rsp_valid}, rsp_rdata); end
        end
        @(negedge wb_clk_i); rsp_ready = 1'b1;
        @(posedge wb_clk_i); #1; rsp_ready = 1'b0;
        total++; if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin bad++; $display("FAIL bp_handoff got=%b want=010", {rsp_valid, cmd_ready, busy}); end
        @(posedge wb_clk_i); #1; cmd_valid = 1'b0;
        total++; if ({cmd_ready, busy} !== 2'b01) begin bad++; $display("FAIL bp_accept got=%b want=01", {cmd_ready, busy}); end
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            @(posedge wb_clk_i); #1;
            if (rsp_valid) found = 1;
        end
        total++; if (found !== 1 || rsp_rdata !== 8'h3C) begin bad++; $display("FAIL bp_second got=%0d/%h want=1/3c", found, rsp_rdata); end
        ack_rsp();
    endtask

    task automatic test_reset_mid_sense();
        int stale;
        arr_out = 8'hC3;
        run_cmd(2'b00, 3'b110, 8'h00, 15);
        total++; if ({sen2, rsp_cyc} !== {1'b1, 32'd0}) begin bad++; $display("FAIL rst_in_sense got=%b/%0d want=1/0", sen2, rsp_cyc); end
        wb_rst_n = 1'b0; #1;
        total++; if (all_out !== 41'd0) begin bad++; $display("FAIL rst_async got=%h want=0", all_out); end
        @(negedge wb_clk_i); wb_rst_n = 1'b1;
        stale = 0;
        repeat (4) begin @(posedge wb_clk_i); #1; if (rsp_valid || busy) stale++; end
        total++; if (stale !== 0) begin bad++; $display("FAIL rst_stale got=%0d want=0", stale); end
        arr_out = 8'h5A;
        run_cmd(2'b00, 3'b000, 8'h00, 40);
        total++; if ({s_ssl, s_gsl, s_wl0, s_wl1} !== 12'b01_01_1110_0000) begin bad++; $display("FAIL rst_read_lines got=%b want=010111100000", {s_ssl, s_gsl, s_wl0, s_wl1}); end
        total++; if (rsp_cyc !== 23 || rsp_rdata !== 8'h5A || rsp_err !== 1'b0) begin bad++; $display("FAIL rst_read_rsp got=%0d/%h/%b want=23/5a/0", rsp_cyc, rsp_rdata, rsp_err); end
        ack_rsp();
    endtask

    initial begin
        test_reset();
        test_read();
        test_erase();
        test_program();
        test_reserved();
        test_back_to_back();
        test_reset_mid_sense();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
